// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_frame_ctrl
//  Purpose  : UART transmit framing controller. Accepts a parallel word and
//             serialises it as start bit, LSB-first data bits, an optional
//             parity bit and one stop bit (two with UART_TX_STOP2_EN).
//             CLK is the bit clock: one serial bit per CLK cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH  width of the parallel data word (default 8)
//  Ports
//    CLK         bit clock, rising-edge active
//    RST         asynchronous reset, active low
//    P_DATA      parallel word, sampled when a request is accepted
//    Data_Valid  single-cycle send request (shared with the parity calculator)
//    PAR_EN      1 = insert a parity bit, sampled when a request is accepted
//    par_bit     registered parity from the upstream parity calculator,
//                valid from the cycle after Data_Valid
//    TX_OUT      registered serial line, idles high
//    Busy        registered, high while a frame is in flight
//  Configuration macro
//    UART_TX_STOP2_EN  defined: every frame ends with two stop bits
//                      undefined: single stop bit, no STOP2 state
// ============================================================================
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    // A one-bit word still needs a one-bit counter.
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
`ifdef UART_TX_STOP2_EN
        ST_STOP2  = 3'd5,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_en_q;
    logic                    par_q;
    logic                    tx_q;
    logic                    busy_q;
    // Low for the first edge after reset release, so a Data_Valid that is
    // high in the cycle reset deasserts is not taken as a request.
    logic                    armed_q;

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    // ------------------------------------------------------------------------
    // Framing FSM. Outputs are registered: the value assigned to tx_q on the
    // edge that enters a state is the bit driven for the whole of that state.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    if (Data_Valid && armed_q) begin
                        shift_q  <= P_DATA;
                        par_en_q <= PAR_EN;
                        tx_q     <= 1'b0;       // start bit
                        busy_q   <= 1'b1;
                        state_q  <= ST_START;
                    end
                end

                ST_START: begin
                    // Parity is taken now and held privately: a later
                    // Data_Valid pulse retriggers the upstream calculator
                    // and would otherwise corrupt this frame's parity.
                    par_q   <= par_bit;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    cnt_q   <= '0;
                    state_q <= ST_DATA;
                end

                ST_DATA: begin
                    if (cnt_q == C_LAST_BIT) begin
                        cnt_q <= '0;
                        if (par_en_q) begin
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end

                ST_PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_STOP;
                end

                ST_STOP: begin
                    tx_q <= 1'b1;
`ifdef UART_TX_STOP2_EN
                    state_q <= ST_STOP2;
`else
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
`endif
                end

`ifdef UART_TX_STOP2_EN
                ST_STOP2: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
`endif

                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_frame_ctrl
//  Purpose  : Self-checking bench for uart_tx_frame_ctrl. Expected serial
//             frames come from a reference model that assembles the bit list
//             directly from the frame format (start, data LSB first, optional
//             parity, stop bits). Honours UART_TX_STOP2_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          par_bit;
    logic          TX_OUT;
    logic          Busy;

    int vectors;
    int miscompares;

    logic exp_q[$];

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: the serial bit list of one frame, in line order.
    function automatic void build_frame(input logic [DW-1:0] d, input logic pen,
                                        input logic pb);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(logic'((d >> i) & 1));
        if (pen) exp_q.push_back(pb);
        for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic int frame_len(input logic pen);
        return 1 + DW + (pen ? 1 : 0) + NSTOP;
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; par_bit = 1'b0;
        #2 RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (TX_OUT !== 1'b1) begin
                miscompares++; $display("FAIL reset_tx cyc %0d: got %b want 1", i, TX_OUT);
            end
            vectors++;
            if (Busy !== 1'b0) begin
                miscompares++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, Busy);
            end
        end
        // Release with a request already present: it must be ignored.
        RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle cyc %0d: got tx=%b busy=%b want tx=1 busy=0", i, TX_OUT, Busy);
            end
            @(negedge CLK);
        end
    endtask

    // One complete frame; inputs are scrambled mid-frame and must not matter.
    task automatic test_frame(input logic [DW-1:0] d, input logic pen, input logic pb,
                              input string nm);
        int len;
        build_frame(d, pen, pb);
        len = frame_len(pen);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pen; par_bit = pb; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA = DW'($urandom); PAR_EN = 1'($urandom);
        for (int i = 0; i < len; i++) begin
            vectors++;
            if (TX_OUT !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s tx slot %0d: got %b want %b", nm, i, TX_OUT, exp_q[i]);
            end
            vectors++;
            if (Busy !== 1'b1) begin
                miscompares++; $display("FAIL %s busy slot %0d: got %b want 1", nm, i, Busy);
            end
            @(negedge CLK);
            par_bit = 1'($urandom);
            P_DATA  = DW'($urandom);
            PAR_EN  = 1'($urandom);
        end
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end_idle: got tx=%b busy=%b want tx=1 busy=0", nm, TX_OUT, Busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int gap;
            test_frame(DW'($urandom), 1'($urandom), 1'($urandom), "random");
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) @(negedge CLK);
        end
    endtask

    task automatic test_parity_hold();
        int len;
        build_frame(8'h03, 1'b1, 1'b1);
        len = frame_len(1'b1);
        @(negedge CLK);
        P_DATA = 8'h03; PAR_EN = 1'b1; par_bit = 1'b1; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            vectors++;
            if (TX_OUT !== exp_q[i] || Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL parity_hold slot %0d: got tx=%b busy=%b want tx=%b busy=1", i, TX_OUT, Busy, exp_q[i]);
            end
            @(negedge CLK);
            par_bit = 1'b0;
            Data_Valid = (i == 4);
            if (i == 4) begin P_DATA = 8'hFF; PAR_EN = 1'b0; end
        end
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                miscompares++;
                $display("FAIL parity_hold no_retrigger cyc %0d: got tx=%b busy=%b want tx=1 busy=0", i, TX_OUT, Busy);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] d;
        d = DW'($urandom);
        build_frame(d, 1'b1, 1'b0);
        @(negedge CLK);
        P_DATA = d; PAR_EN = 1'b1; par_bit = 1'b0; Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        // slot 0 = start bit, slot 5 = data bit 4
        for (int i = 0; i < 5; i++) @(negedge CLK);
        vectors++;
        if (TX_OUT !== exp_q[5]) begin
            miscompares++; $display("FAIL midreset bit4: got %b want %b", TX_OUT, exp_q[5]);
        end
        #1 RST = 1'b0;
        #1;
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset async: got tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            vectors++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset abandoned cyc %0d: got tx=%b busy=%b want tx=1 busy=0", i, TX_OUT, Busy);
            end
        end
        test_frame(8'hFF, 1'($urandom), 1'($urandom), "after_reset_ff");
    endtask

    // Data_Valid held high: frames repeat every frame length + 1 cycles.
    task automatic test_back_to_back();
        logic [DW-1:0] pd [0:63];
        logic          pb [0:63];
        logic          pen;
        int            len;
        int            ncyc;
        pen  = 1'($urandom);
        len  = frame_len(pen);
        ncyc = 3 * (len + 1) + 1;
        @(negedge CLK);
        pd[0] = DW'($urandom); pb[0] = 1'($urandom);
        P_DATA = pd[0]; par_bit = pb[0]; PAR_EN = pen; Data_Valid = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            int k, pos, s;
            @(negedge CLK);
            k   = (c - 1) / (len + 1);
            pos = (c - 1) % (len + 1);
            s   = 1 + k * (len + 1);
            if (pos < len) begin
                build_frame(pd[k * (len + 1)], pen, pb[s]);
                vectors++;
                if (TX_OUT !== exp_q[pos] || Busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b frame %0d slot %0d: got tx=%b busy=%b want tx=%b busy=1", k, pos, TX_OUT, Busy, exp_q[pos]);
                end
            end else begin
                vectors++;
                if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b gap after frame %0d: got tx=%b busy=%b want tx=1 busy=0", k, TX_OUT, Busy);
                end
            end
            pd[c] = DW'($urandom); pb[c] = 1'($urandom);
            P_DATA = pd[c]; par_bit = pb[c];
        end
        Data_Valid = 1'b0;
        for (int i = 0; i < len + 2; i++) @(negedge CLK);
        vectors++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b drain: got tx=%b busy=%b want tx=1 busy=0", TX_OUT, Busy);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_frame(8'hA5, 1'b1, 1'b0, "a5_parity");
        test_frame(8'h01, 1'b0, 1'b1, "01_noparity");
        test_random();
        test_parity_hold();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
